// File: rtl/reg_pkg.sv
// Shared constants and FSM state type for the register read unit.
// The operand bypass is selected at build time with the macro RD_BYPASS_EN.
package reg_pkg;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam logic [4:0]  REG_SP          = 5'd29;
  localparam logic [4:0]  REG_RA          = 5'd31;
  localparam logic [31:0] SP_INIT_DEFAULT = 32'd227;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/reg_array.sv
// 32-entry register bank: one synchronous write port, two asynchronous read ports.
// Register 0 is hardwired to zero and register 29 resets to SP_INIT.
module reg_array
  import reg_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [ADDR_W-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
      r_mem[ADDR_W'(REG_SP)] <= DATA_W'(SP_INIT);
    end else if (i_wr_en && (i_wr_addr != ADDR_W'(REG_ZERO))) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Entry 0 is never written, but mask it anyway so it reads zero by construction.
  assign o_ra_data = (i_ra_addr == ADDR_W'(REG_ZERO)) ? '0 : r_mem[i_ra_addr];
  assign o_rb_data = (i_rb_addr == ADDR_W'(REG_ZERO)) ? '0 : r_mem[i_rb_addr];

endmodule

// File: rtl/reg_read_unit.sv
// Sequenced two-operand register read (IDLE -> READ -> DONE) into the A/B operand latches.
// Build option RD_BYPASS_EN forwards a write landing during READ into the latches.
module reg_read_unit
  import reg_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output rd_state_t         dbg_state
);

  // Handshake: rd_req is sampled only in IDLE; rd_busy is high for the one READ
  // cycle; rd_valid pulses for the one DONE cycle, when a_out/b_out carry the new
  // operands. Requests arriving in READ or DONE are dropped, not queued.

  rd_state_t         r_state;
  rd_state_t         w_next;
  logic [ADDR_W-1:0] r_rs;
  logic [ADDR_W-1:0] r_rt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_a_next;
  logic [DATA_W-1:0] w_b_next;

  reg_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_reg_array (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_ra_addr (r_rs),
    .o_ra_data (w_rs_data),
    .i_rb_addr (r_rt),
    .o_rb_data (w_rt_data)
  );

`ifdef RD_BYPASS_EN
  // A write retiring on the same edge as READ would otherwise be missed by the latch.
  logic w_hit_a;
  logic w_hit_b;
  assign w_hit_a  = wr_en && (wr_addr == r_rs) && (r_rs != ADDR_W'(REG_ZERO));
  assign w_hit_b  = wr_en && (wr_addr == r_rt) && (r_rt != ADDR_W'(REG_ZERO));
  assign w_a_next = w_hit_a ? wr_data : w_rs_data;
  assign w_b_next = w_hit_b ? wr_data : w_rt_data;
`else
  assign w_a_next = w_rs_data;
  assign w_b_next = w_rt_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rs    <= '0;
      r_rt    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && rd_req) begin
        r_rs <= rs_addr;
        r_rt <= rt_addr;
      end
      if (r_state == READ) begin
        r_a <= w_a_next;
        r_b <= w_b_next;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = rd_req ? READ : IDLE;
      READ:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign rd_busy   = (r_state == READ);
  assign rd_valid  = (r_state == DONE);
  assign a_out     = r_a;
  assign b_out     = r_b;
  assign dbg_state = r_state;

endmodule
